// File: rtl/pwm_ramp_ctrl.sv
// Slew-limited, direction-safe duty command generator for a PWM stage,
// with filtered overcurrent detection, timed retry and lockout.
module pwm_ramp_ctrl #(
    parameter int PERIOD_END    = 2000,
    parameter int MAX_DUTY      = 2000,
    parameter int STEP          = 16,
    parameter int DEAD_PERIODS  = 4,
    parameter int OC_FILT       = 3,
    parameter int RETRY_PERIODS = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CLEAR_PERIODS = 256
) (
    input  logic        i_clk,
    input  logic        RESET,
    input  logic        Enable,
    input  logic [11:0] Cmd_in,
    input  logic [10:0] Count,
    input  logic        OFF_in,
    output logic [11:0] Pwm_cmd,
    output logic [2:0]  State,
    output logic        Fault,
    output logic        Busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RAMP    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_DEAD    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    localparam logic signed [12:0] MAX_S       = 13'(MAX_DUTY);
    localparam logic signed [12:0] STEP_S      = 13'(STEP);
    localparam logic [15:0]        DEAD_LAST   = 16'(DEAD_PERIODS - 1);
    localparam logic [15:0]        RETRY_LAST  = 16'(RETRY_PERIODS - 1);
    localparam logic [15:0]        CLEAR_LAST  = 16'(CLEAR_PERIODS - 1);
    localparam logic [3:0]         OC_LAST     = 4'(OC_FILT - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRY);

    logic [2:0]         state_r, state_n;
    logic signed [11:0] cur_r, cur_n;
    logic [15:0]        pcnt_r, pcnt_n;
    logic [3:0]         retry_r, retry_n, retry_inc_s;
    logic [3:0]         oc_cnt_r, oc_cnt_n;
    logic               fault_r, busy_r;
    logic               strobe_s, active_s, trip_s, opposite_s;
    logic signed [12:0] cmd_ext_s, cur_ext_s, target_s, aim_s, diff_s, stepped_s;

    assign strobe_s    = (Count == 11'(PERIOD_END));
    assign active_s    = (state_r == S_RAMP) || (state_r == S_RUN) || (state_r == S_DEAD);
    assign trip_s      = OFF_in && active_s && (oc_cnt_r == OC_LAST);
    assign retry_inc_s = (retry_r == 4'hF) ? retry_r : retry_r + 4'd1;

    assign Pwm_cmd = cur_r;
    assign State   = state_r;
    assign Fault   = fault_r;
    assign Busy    = busy_r;

    // Saturated target, and one slew step toward it (or toward zero when reversing).
    always_comb begin
        cmd_ext_s = {Cmd_in[11], Cmd_in};
        cur_ext_s = {cur_r[11], cur_r};
        if (!Enable) begin
            target_s = 13'sd0;
        end else if (cmd_ext_s > MAX_S) begin
            target_s = MAX_S;
        end else if (cmd_ext_s < -MAX_S) begin
            target_s = -MAX_S;
        end else begin
            target_s = cmd_ext_s;
        end
        opposite_s = (cur_ext_s != 13'sd0) && (target_s != 13'sd0) &&
                     (cur_ext_s[12] != target_s[12]);
        if (opposite_s) begin
            aim_s = 13'sd0;
        end else begin
            aim_s = target_s;
        end
        diff_s = aim_s - cur_ext_s;
        if (diff_s > STEP_S) begin
            stepped_s = cur_ext_s + STEP_S;
        end else if (diff_s < -STEP_S) begin
            stepped_s = cur_ext_s - STEP_S;
        end else begin
            stepped_s = aim_s;
        end
    end

    // Overcurrent filter: consecutive high clocks while driving.
    always_comb begin
        if (OFF_in && active_s && !trip_s) begin
            oc_cnt_n = oc_cnt_r + 4'd1;
        end else begin
            oc_cnt_n = 4'd0;
        end
    end

    // Next-state logic; a filtered overcurrent wins over any strobe activity.
    always_comb begin
        state_n = state_r;
        cur_n   = cur_r;
        pcnt_n  = pcnt_r;
        retry_n = retry_r;
        if (trip_s) begin
            cur_n   = 12'sd0;
            retry_n = retry_inc_s;
            if (retry_inc_s >= RETRY_LIMIT) begin
                state_n = S_LOCKOUT;
            end else begin
                state_n = S_FAULT;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    cur_n = 12'sd0;
                    if (Enable) begin
                        state_n = S_RAMP;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_RAMP: begin
                    if ((cur_ext_s == target_s) && (target_s != 13'sd0)) begin
                        state_n = S_RUN;
                    end else if ((cur_ext_s == 13'sd0) && !Enable) begin
                        state_n = S_IDLE;
                    end else if (strobe_s) begin
                        cur_n = stepped_s[11:0];
                        if (opposite_s && (stepped_s == 13'sd0)) begin
                            state_n = S_DEAD;
                        end else begin
                            state_n = S_RAMP;
                        end
                    end else begin
                        state_n = S_RAMP;
                    end
                end
                S_RUN: begin
                    if (target_s != cur_ext_s) begin
                        state_n = S_RAMP;
                    end else if (strobe_s) begin
                        if (pcnt_r == CLEAR_LAST) begin
                            retry_n = 4'd0;
                            pcnt_n  = 16'd0;
                        end else begin
                            pcnt_n = pcnt_r + 16'd1;
                        end
                    end else begin
                        state_n = S_RUN;
                    end
                end
                S_DEAD: begin
                    cur_n = 12'sd0;
                    if (strobe_s) begin
                        if (pcnt_r == DEAD_LAST) begin
                            state_n = S_RAMP;
                        end else begin
                            pcnt_n = pcnt_r + 16'd1;
                        end
                    end else begin
                        state_n = S_DEAD;
                    end
                end
                S_FAULT: begin
                    cur_n = 12'sd0;
                    if (strobe_s) begin
                        if (pcnt_r == RETRY_LAST) begin
                            state_n = S_RAMP;
                        end else begin
                            pcnt_n = pcnt_r + 16'd1;
                        end
                    end else begin
                        state_n = S_FAULT;
                    end
                end
                S_LOCKOUT: begin
                    cur_n = 12'sd0;
                    if (!Enable) begin
                        state_n = S_IDLE;
                        retry_n = 4'd0;
                    end else begin
                        state_n = S_LOCKOUT;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cur_n   = 12'sd0;
                end
            endcase
        end
        // Period counting restarts whenever the state changes.
        if (state_n != state_r) begin
            pcnt_n = 16'd0;
        end else begin
            pcnt_n = pcnt_n;
        end
    end

    // State, duty and counter registers with registered status flags.
    always_ff @(posedge i_clk or negedge RESET) begin
        if (!RESET) begin
            state_r  <= S_IDLE;
            cur_r    <= 12'sd0;
            pcnt_r   <= 16'd0;
            retry_r  <= 4'd0;
            oc_cnt_r <= 4'd0;
            fault_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            cur_r    <= cur_n;
            pcnt_r   <= pcnt_n;
            retry_r  <= retry_n;
            oc_cnt_r <= oc_cnt_n;
            fault_r  <= (state_n == S_FAULT) || (state_n == S_LOCKOUT);
            busy_r   <= (state_n != S_IDLE) && (state_n != S_LOCKOUT);
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: integer behavioural model checked every cycle,
// plus directed scenarios with hand-computed duty/state expectations.
module tb_pwm_ramp_ctrl;
    logic        i_clk, RESET, Enable, OFF_in;
    logic [11:0] Cmd_in;
    logic [10:0] Count;
    logic [11:0] Pwm_cmd;
    logic [2:0]  State;
    logic        Fault, Busy;

    int checks = 0;
    int failures = 0;
    int m_mode = 0, m_duty = 0, m_cnt = 0, m_retry = 0, m_oc = 0;

    pwm_ramp_ctrl dut (
        .i_clk(i_clk), .RESET(RESET), .Enable(Enable), .Cmd_in(Cmd_in),
        .Count(Count), .OFF_in(OFF_in), .Pwm_cmd(Pwm_cmd), .State(State),
        .Fault(Fault), .Busy(Busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp_tgt(input logic en, input logic [11:0] c);
        int v;
        v = $signed(c);
        if (!en) return 0;
        if (v > 2000) return 2000;
        if (v < -2000) return -2000;
        return v;
    endfunction

    function automatic int approach(input int from, input int to);
        if (to - from > 16) return from + 16;
        if (from - to > 16) return from - 16;
        return to;
    endfunction

    task automatic model_step();
        int  tgt;
        bit  stb, active;
        tgt    = clamp_tgt(Enable, Cmd_in);
        stb    = (Count == 11'd2000);
        active = (m_mode >= 1) && (m_mode <= 3);
        m_oc   = (OFF_in && active) ? m_oc + 1 : 0;
        if (m_oc >= 3) begin
            m_oc    = 0;
            m_retry = m_retry + 1;
            m_duty  = 0;
            m_cnt   = 0;
            m_mode  = (m_retry >= 3) ? 5 : 4;
        end else begin
            case (m_mode)
                0: if (Enable) m_mode = 1;
                1: begin
                    if (m_duty == tgt && tgt != 0) begin
                        m_mode = 2; m_cnt = 0;
                    end else if (m_duty == 0 && !Enable) begin
                        m_mode = 0;
                    end else if (stb) begin
                        if (m_duty * tgt < 0) begin
                            m_duty = approach(m_duty, 0);
                            if (m_duty == 0) begin m_mode = 3; m_cnt = 0; end
                        end else begin
                            m_duty = approach(m_duty, tgt);
                        end
                    end
                end
                2: begin
                    if (tgt != m_duty) begin
                        m_mode = 1;
                    end else if (stb) begin
                        m_cnt++;
                        if (m_cnt == 256) begin m_retry = 0; m_cnt = 0; end
                    end
                end
                3: if (stb) begin
                    m_cnt++;
                    if (m_cnt == 4) begin m_mode = 1; m_cnt = 0; end
                end
                4: if (stb) begin
                    m_cnt++;
                    if (m_cnt == 64) begin m_mode = 1; m_cnt = 0; end
                end
                5: if (!Enable) begin m_mode = 0; m_retry = 0; end
                default: m_mode = 0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk or negedge RESET);
            if (!RESET) begin
                m_mode = 0; m_duty = 0; m_cnt = 0; m_retry = 0; m_oc = 0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            check("model_pwm", $signed(Pwm_cmd), m_duty);
            check("model_state", int'(State), m_mode);
            check("model_fault", int'(Fault), (m_mode == 4 || m_mode == 5) ? 1 : 0);
            check("model_busy", int'(Busy), (m_mode != 0 && m_mode != 5) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic strobe();
        @(negedge i_clk);
        Count = 11'd2000;
        @(negedge i_clk);
        Count = 11'd0;
    endtask

    task automatic trip(input int clocks);
        @(negedge i_clk);
        OFF_in = 1'b1;
        repeat (clocks) @(negedge i_clk);
        OFF_in = 1'b0;
    endtask

    task automatic recover();
        repeat (64) strobe();
        repeat (3) strobe();
        cyc(2);
    endtask

    int exp_down[4] = '{84, 68, 52, 40};
    int exp_rev[10] = '{24, 8, 0, 0, 0, 0, 0, -16, -32, -40};
    int st_rev[10]  = '{1, 1, 3, 3, 3, 3, 1, 1, 1, 1};

    initial begin
        RESET = 1'b0; Enable = 1'b0; Cmd_in = 12'd0; Count = 11'd0; OFF_in = 1'b0;
        cyc(3);
        check("rst_state", int'(State), 0);
        check("rst_pwm", $signed(Pwm_cmd), 0);
        check("rst_fault", int'(Fault), 0);
        check("rst_busy", int'(Busy), 0);
        RESET = 1'b1;
        cyc(2);

        Enable = 1'b1; Cmd_in = 12'd100;
        cyc(2);
        check("idle_to_ramp", int'(State), 1);
        check("ramp_busy", int'(Busy), 1);
        for (int k = 1; k <= 7; k++) begin
            strobe();
            check("ramp100_pwm", $signed(Pwm_cmd), (16 * k > 100) ? 100 : 16 * k);
        end
        cyc(2);
        check("run100_state", int'(State), 2);

        Cmd_in = 12'd40;
        cyc(1);
        check("run_to_ramp", int'(State), 1);
        for (int k = 0; k < 4; k++) begin
            strobe();
            check("ramp40_pwm", $signed(Pwm_cmd), exp_down[k]);
        end
        cyc(2);
        check("run40_state", int'(State), 2);

        Cmd_in = 12'hFD8;
        cyc(1);
        for (int k = 0; k < 10; k++) begin
            strobe();
            check("reverse_pwm", $signed(Pwm_cmd), exp_rev[k]);
            check("reverse_state", int'(State), st_rev[k]);
        end
        cyc(2);
        check("runm40_state", int'(State), 2);

        trip(2);
        cyc(3);
        check("oc_glitch_state", int'(State), 2);
        trip(3);
        check("oc_pwm", $signed(Pwm_cmd), 0);
        check("oc_state", int'(State), 4);
        check("oc_fault", int'(Fault), 1);
        repeat (63) strobe();
        check("retry_wait_state", int'(State), 4);
        strobe();
        check("retry_done_state", int'(State), 1);
        repeat (3) strobe();
        cyc(2);
        check("retry_run_state", int'(State), 2);

        trip(3);
        check("oc2_state", int'(State), 4);
        recover();
        trip(3);
        check("lockout_state", int'(State), 5);
        check("lockout_fault", int'(Fault), 1);
        check("lockout_busy", int'(Busy), 0);
        cyc(5);
        check("lockout_hold", int'(State), 5);
        Enable = 1'b0;
        cyc(1);
        check("lockout_exit_state", int'(State), 0);
        check("lockout_exit_fault", int'(Fault), 0);

        Enable = 1'b1;
        cyc(2);
        repeat (3) strobe();
        cyc(2);
        trip(3);
        recover();
        trip(3);
        check("clr_pre_state", int'(State), 4);
        recover();
        repeat (256) strobe();
        trip(3);
        check("retry_cleared_state", int'(State), 4);
        repeat (64) strobe();
        strobe();
        check("pre_reset_state", int'(State), 1);
        check("pre_reset_pwm", $signed(Pwm_cmd), -16);
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst_pwm", $signed(Pwm_cmd), 0);
        check("async_rst_state", int'(State), 0);
        check("async_rst_fault", int'(Fault), 0);
        check("async_rst_busy", int'(Busy), 0);
        @(negedge i_clk);
        RESET = 1'b1;

        Cmd_in = 12'd2047;
        cyc(2);
        repeat (125) strobe();
        check("sat_pos_pwm", $signed(Pwm_cmd), 2000);
        cyc(2);
        check("sat_pos_state", int'(State), 2);
        Cmd_in = 12'h800;
        cyc(1);
        repeat (254) strobe();
        check("sat_neg_pwm", $signed(Pwm_cmd), -2000);
        cyc(2);
        check("sat_neg_state", int'(State), 2);
        Enable = 1'b0;
        cyc(1);
        repeat (125) strobe();
        check("disable_pwm", $signed(Pwm_cmd), 0);
        cyc(2);
        check("disable_state", int'(State), 0);
        check("disable_busy", int'(Busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_END, default 2000, Count value marking end of PWM period (update strobe).
REQ-002 SHALL have parameter MAX_DUTY, default 2000, saturation limit for duty magnitude.
REQ-003 SHALL have parameter STEP, default 16, max duty change per period.
REQ-004 SHALL have parameter DEAD_PERIODS, default 4, zero-duty periods before direction reversal.
REQ-005 SHALL have parameters OC_FILT (3, clocks), RETRY_PERIODS (64), MAX_RETRY (3), CLEAR_PERIODS (256).
REQ-006 SHALL have port i_clk  input  1  system clock, all logic on rising edge (one clock).
REQ-007 SHALL have port RESET  input  1  asynchronous active-low reset.
REQ-008 SHALL have port Enable  input  1  run request.
REQ-009 SHALL have port Cmd_in  input  12  signed two's-complement target duty.
REQ-010 SHALL have port Count  input  11  period counter from PWM stage.
REQ-011 SHALL have port OFF_in  input  1  overcurrent flag from PWM stage.
REQ-012 SHALL have port Pwm_cmd  output  12  signed duty command to PWM stage, registered.
REQ-013 SHALL have port State  output  3  FSM state code.
REQ-014 SHALL have port Fault  output  1  high in FAULT or LOCKOUT.
REQ-015 SHALL have port Busy  output  1  high in any state except IDLE and LOCKOUT.

Function
REQ-016 SHALL encode states IDLE=0, RAMP=1, RUN=2, DEAD=3, FAULT=4, LOCKOUT=5; codes 6-7 recover to IDLE next clock.
REQ-017 SHALL generate strobe on clock where Count==PERIOD_END; ramp/dead/retry counters advance only on strobe.
REQ-018 SHALL saturate target: magnitude > MAX_DUTY clipped to +/-MAX_DUTY (incl. -2048 -> -MAX_DUTY); Enable=0 forces target 0.
REQ-019 SHALL update Pwm_cmd on ramp one clock after strobe (registered, latency 1).
REQ-020 IDLE: Pwm_cmd=0; Enable=1 -> RAMP.
REQ-021 RAMP, same sign or current 0: per strobe move current toward target by STEP; if |target-current|<=STEP, load target exactly (no overshoot).
REQ-022 RAMP, target sign opposite current (current nonzero): ramp toward 0; at 0 -> DEAD.
REQ-023 DEAD: Pwm_cmd=0 for DEAD_PERIODS strobes, then RAMP toward new sign.
REQ-024 current==target and target!=0 -> RUN; current==0 and Enable=0 -> IDLE.
REQ-025 RUN: target change or Enable=0 -> RAMP next clock.
REQ-026 Overcurrent: OFF_in high OC_FILT consecutive clocks in RAMP/RUN/DEAD -> FAULT; Pwm_cmd=0 next clock, not waiting for strobe; retry counter +1.
REQ-027 Fault detection SHALL take priority over strobe in same clock.
REQ-028 FAULT entry with retry counter reaching MAX_RETRY -> LOCKOUT; else wait RETRY_PERIODS strobes then RAMP from 0.
REQ-029 LOCKOUT: Pwm_cmd=0; leave to IDLE only when Enable=0; retry counter cleared on exit.
REQ-030 Retry counter SHALL clear after CLEAR_PERIODS consecutive strobes in RUN.
REQ-031 OFF_in filter count SHALL reset whenever OFF_in low.

Reset
REQ-032 RESET low SHALL asynchronously force Pwm_cmd=0, State=IDLE, Fault=0, Busy=0, all counters 0.
REQ-033 RESET mid-ramp or in LOCKOUT SHALL abort immediately; release resumes in IDLE.

Verification
REQ-034 Enable=1, Cmd_in=100 -> Pwm_cmd 16,32,...,96,100 on successive strobes, then RUN.
REQ-035 RUN at +40, Cmd_in=-40 -> 40,24,8,0, DEAD for 4 strobes, then -16,-32,-40.
REQ-036 Cmd_in=0x800 -> target -2000; Cmd_in=2047 -> target 2000.
REQ-037 OFF_in high 2 clocks -> no fault; 3 clocks -> Pwm_cmd=0 next clock, State=4, Fault=1, RAMP after 64 strobes.
REQ-038 Three faults without 256 RUN strobes between -> LOCKOUT; Enable=0 -> IDLE, Fault=0.
REQ-039 RESET low during RAMP -> Pwm_cmd=0, State=0 same cycle, without a clock edge.
